// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes and burst FSM states.
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHR  = 3'b001;
    localparam logic [2:0] USR_SHL  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROR  = 3'b100;
    localparam logic [2:0] USR_ROL  = 3'b101;
    localparam logic [2:0] USR_ASR  = 3'b110;
    localparam logic [2:0] USR_CLR  = 3'b111;

    typedef enum logic {
        USR_IDLE = 1'b0,
        USR_RUN  = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: IDLE/RUN FSM that decides when the register applies an op and
// which mode it uses, with a remaining-ops counter and busy/done reporting.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [2:0]       mode,
    output logic             op_en,
    output logic [2:0]       op_mode,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        op_en   = 1'b0;
        op_mode = mode;
        if (enable) begin
            case (state_q)
                USR_IDLE: begin
                    if (start) begin
                        // The start edge only arms the burst; the first op happens next edge.
                        if (count != '0) begin
                            mode_d  = mode;
                            rem_d   = count;
                            state_d = USR_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        op_en = 1'b1;
                    end
                end
                USR_RUN: begin
                    op_en   = 1'b1;
                    op_mode = mode_q;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = USR_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = USR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= USR_IDLE;
            rem_q   <= '0;
            mode_q  <= USR_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == USR_RUN);
    assign done = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register (hold/shift/rotate/asr/load/clear) with burst sequencer.
// Optional even-parity output enabled by defining USR_PARITY_EN.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             op_en;
    logic [2:0]       op_mode;

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             si,
        input logic [WIDTH-1:0] dd
    );
        case (m)
            USR_HOLD: apply_mode = v;
            USR_SHR:  apply_mode = {si, v[WIDTH-1:1]};
            USR_SHL:  apply_mode = {v[WIDTH-2:0], si};
            USR_LOAD: apply_mode = dd;
            USR_ROR:  apply_mode = {v[0], v[WIDTH-1:1]};
            USR_ROL:  apply_mode = {v[WIDTH-2:0], v[WIDTH-1]};
            USR_ASR:  apply_mode = {v[WIDTH-1], v[WIDTH-1:1]};
            USR_CLR:  apply_mode = '0;
            default:  apply_mode = v;
        endcase
    endfunction

    usr_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (start),
        .count   (count),
        .mode    (mode),
        .op_en   (op_en),
        .op_mode (op_mode),
        .busy    (busy),
        .done    (done)
    );

    // d and ser_in stay live during a burst; only the mode is latched.
    always_comb begin
        q_d = q_q;
        if (op_en) begin
            q_d = apply_mode(op_mode, q_q, ser_in, d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q           = q_q;
    assign ser_out_lsb = q_q[0];
    assign ser_out_msb = q_q[WIDTH-1];

`ifdef USR_PARITY_EN
    assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8, CNT_W=4): directed cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'd0;
    logic       ser_in = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] q;
    logic       ser_out_lsb, ser_out_msb, busy, done;
`ifdef USR_PARITY_EN
    logic       parity;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    logic [7:0] m_q = 8'd0;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         m_rem = 0;
    logic [2:0] m_mode = 3'd0;

    universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .d           (d),
        .ser_in      (ser_in),
        .start       (start),
        .count       (count),
        .q           (q),
        .ser_out_lsb (ser_out_lsb),
        .ser_out_msb (ser_out_msb),
        .busy        (busy),
        .done        (done)
`ifdef USR_PARITY_EN
        ,
        .parity      (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_op(input logic [2:0] md, input logic [7:0] v,
                                            input logic si, input logic [7:0] dd);
        int u;
        u = v;
        case (md)
            3'd0: model_op = v;
            3'd1: model_op = 8'((u / 2) + (si ? 128 : 0));
            3'd2: model_op = 8'((u * 2) % 256 + (si ? 1 : 0));
            3'd3: model_op = dd;
            3'd4: model_op = 8'((u / 2) + ((u % 2) * 128));
            3'd5: model_op = 8'((u * 2) % 256 + (u / 128));
            3'd6: model_op = 8'((u / 2) + (u >= 128 ? 128 : 0));
            default: model_op = 8'd0;
        endcase
    endfunction

    task automatic model_step();
        if (!enable) begin
            m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (!m_busy) begin
            if (start) begin
                if (count != 0) begin
                    m_busy = 1'b1;
                    m_rem  = count;
                    m_mode = mode;
                end else begin
                    m_done = 1'b1;
                end
            end else begin
                m_q = model_op(mode, m_q, ser_in, d);
            end
        end else begin
            m_q = model_op(m_mode, m_q, ser_in, d);
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        m_q = 8'd0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 3'd0;
        #1;
        chk("async_reset_q", q, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_in(input bit en, input logic [2:0] md, input logic [7:0] dd,
                          input bit si, input bit st, input logic [3:0] cnt);
        enable = en; mode = md; d = dd; ser_in = si; start = st; count = cnt;
    endtask

    task automatic load(input logic [7:0] v);
        set_in(1, 3'd3, v, 0, 0, 0);
        cyc();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q", q, m_q);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("ser_out_lsb", ser_out_lsb, m_q[0]);
            chk("ser_out_msb", ser_out_msb, m_q[7]);
`ifdef USR_PARITY_EN
            chk("parity", parity, ^m_q);
`endif
        end
    end

    initial begin
        int nb;
        // reset with a non-zero q
        #12;
        reset = 1'b0;
        chk_en = 1'b1;
        load(8'h5A);
        chk("preload", q, 8'h5A);
        do_reset();

        // load then hold while disabled
        load(8'hA5);
        chk("load_a5", q, 8'hA5);
        set_in(0, 3'd1, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("en0_hold", q, 8'hA5);
        end

        // single-step modes
        set_in(1, 3'd5, 8'h00, 0, 0, 0); cyc();
        chk("rol_a5", q, 8'h4B);
        load(8'h85);
        set_in(1, 3'd6, 8'h00, 0, 0, 0); cyc();
        chk("asr_85", q, 8'hC2);
        load(8'h81);
        set_in(1, 3'd4, 8'h00, 1, 0, 0); cyc();
        chk("ror_81", q, 8'hC0);

        // burst SHR x3, mode toggled mid-burst
        load(8'h81);
        set_in(1, 3'd1, 8'h00, 0, 1, 4'd3); cyc();
        chk("burst_arm_q", q, 8'h81);
        chk("burst_arm_busy", busy, 1);
        set_in(1, 3'd2, 8'hFF, 0, 0, 0); cyc();
        chk("burst_op1", q, 8'h40);
        set_in(1, 3'd7, 8'hFF, 0, 1, 4'd9); cyc();
        chk("burst_op2", q, 8'h20);
        set_in(1, 3'd3, 8'hFF, 0, 0, 0); cyc();
        chk("burst_op3", q, 8'h10);
        chk("burst_done", done, 1);
        chk("burst_idle", busy, 0);
        set_in(1, 3'd0, 8'h00, 0, 0, 0); cyc();
        chk("burst_done_clear", done, 0);

        // burst of 4 with two disabled cycles mid-burst
        set_in(1, 3'd2, 8'h00, 1, 1, 4'd4); cyc();
        start = 0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            nb++;
            enable = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            cyc();
        end
        chk("burst_stall_len", nb, 6);

        // reset in the middle of a burst
        set_in(1, 3'd2, 8'h00, 1, 1, 4'd5); cyc();
        start = 0; cyc(); cyc();
        do_reset();
        set_in(1, 3'd0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_no_done", done, 0);
            chk("abort_busy", busy, 0);
        end

        // zero-length burst
        load(8'h3C);
        set_in(1, 3'd7, 8'h00, 0, 1, 4'd0); cyc();
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_q", q, 8'h3C);
        set_in(1, 3'd0, 8'h00, 0, 0, 0); cyc();
        chk("zero_done_clear", done, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(63) == 0) begin
                do_reset();
            end else begin
                set_in($urandom_range(7) != 0, 3'($urandom), 8'($urandom), 1'($urandom),
                       $urandom_range(5) == 0,
                       ($urandom_range(7) == 0) ? 4'd15 : 4'($urandom_range(0, 6)));
                cyc();
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
